// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small power-of-two byte FIFO.
// A byte offered with tx_valid/tx_ready lands in the FIFO. The frame engine
// pulls bytes out of the FIFO and sends them back to back with no idle
// cycles between frames.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD,
  output logic       busy
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             busy_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             bit_end;
  logic             push;
  logic             pop;
  logic             busy_d;

  // Ready is gated by RESET so nothing can be accepted while reset is held.
  assign tx_ready = ~fifo_full & ~RESET;
  assign TXD      = txd_q;
  assign busy     = busy_q;

  // FIFO handshake, pop timing and next occupancy.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FIFO_FULL);
    bit_end    = (cnt_q == CNT_LAST);
    push       = tx_valid & tx_ready;
    pop        = ~fifo_empty &
                 ((state_q == IDLE) | ((state_q == STOP) & bit_end));
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // Next cycle is busy unless the engine will be idle with an empty FIFO.
    busy_d = pop | (count_d != '0) |
             ((state_q != IDLE) & ~((state_q == STOP) & bit_end));
  end

  // FIFO storage; writes are already blocked during reset through tx_ready.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // Frame engine, FIFO pointers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          txd_q     <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end

        START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit with a 4-entry FIFO.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       CLK;
  logic       RESET;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       TXD;
  logic       busy;

  int n_pass;
  int n_total;

  // Loopback receiver state
  logic       rx_en;
  logic       rx_prev;
  logic [7:0] rx_q [$];
  int         rx_ferr;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TXD     (TXD),
    .busy    (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected line level at offset off (0..FRAME-1) into the frame of byte b.
  function automatic logic exp_txd(input logic [7:0] b, input int off);
    logic [7:0] t;
    if (off < CPB) return 1'b0;
    if (off >= 9 * CPB) return 1'b1;
    t = b >> ((off - CPB) / CPB);
    return t[0];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural 8N1 receiver sampling mid-bit on falling clock edges.
  initial begin
    rx_prev = 1'b1;
    rx_ferr = 0;
    forever begin
      @(negedge CLK);
      if (rx_en && rx_prev === 1'b1 && TXD === 1'b0) begin
        logic [7:0] d;
        d = 8'h00;
        repeat (CPB / 2) @(negedge CLK);
        if (TXD !== 1'b0) rx_ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          d = {TXD, d[7:1]};
        end
        repeat (CPB) @(negedge CLK);
        if (TXD !== 1'b1) rx_ferr++;
        rx_q.push_back(d);
      end
      rx_prev = TXD;
    end
  end

  task automatic test_reset();
    RESET    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    #1;
    n_total++;
    if (tx_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", tx_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (TXD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", TXD);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if (tx_ready !== 1'b0) $display("FAIL reset_ready_held: got %b expected 0", tx_ready);
    else n_pass++;
    RESET    = 1'b0;
    tx_valid = 1'b0;
    #1;
    n_total++;
    if (tx_ready !== 1'b1) $display("FAIL reset_ready_release: got %b expected 1", tx_ready);
    else n_pass++;
    // Byte offered during reset must not show up on the line.
    for (int k = 0; k < 6; k++) begin
      tick();
      n_total++;
      if (TXD !== 1'b1 || busy !== 1'b0)
        $display("FAIL reset_no_accept: cycle %0d txd=%b busy=%b expected txd=1 busy=0", k, TXD, busy);
      else n_pass++;
    end
  endtask

  task automatic test_single_byte();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_total++;
    if (TXD !== 1'b1 || busy !== 1'b1)
      $display("FAIL single_accept: txd=%b busy=%b expected txd=1 busy=1", TXD, busy);
    else n_pass++;
    for (int k = 1; k <= 41; k++) begin
      logic exp_l;
      logic exp_b;
      tick();
      exp_l = (k <= FRAME) ? exp_txd(8'hA5, k - 1) : 1'b1;
      exp_b = (k <= FRAME);
      n_total++;
      if (TXD !== exp_l || busy !== exp_b)
        $display("FAIL single_frame: edge E+%0d txd=%b busy=%b expected txd=%b busy=%b", k, TXD, busy, exp_l, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    seq[2] = 8'h55;
    for (int n = 0; n <= 121; n++) begin
      tx_valid = (n < 3);
      if (n < 3) tx_data = seq[n];
      tick();
      if (n >= 1) begin
        int   j;
        logic exp_l;
        j = n - 1;
        exp_l = 1'b1;
        if (j < 3 * FRAME) exp_l = exp_txd(seq[j / FRAME], j % FRAME);
        n_total++;
        if (TXD !== exp_l)
          $display("FAIL b2b_txd: cycle %0d got %b expected %b", j, TXD, exp_l);
        else n_pass++;
      end
      if (n == 120 || n == 121) begin
        n_total++;
        if (busy !== (n == 120))
          $display("FAIL b2b_busy: edge %0d got %b expected %b", n, busy, n == 120);
        else n_pass++;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_full_fifo();
    logic [7:0] offer [6];
    offer[0] = 8'h11; offer[1] = 8'h22; offer[2] = 8'h33;
    offer[3] = 8'h44; offer[4] = 8'h55; offer[5] = 8'h66;
    for (int n = 0; n <= 202; n++) begin
      tx_valid = (n < 6);
      if (n < 6) begin
        tx_data = offer[n];
        n_total++;
        if (tx_ready !== (n < 5))
          $display("FAIL full_ready: before edge %0d got %b expected %b", n, tx_ready, n < 5);
        else n_pass++;
      end
      tick();
      if (n >= 1) begin
        int   j;
        logic exp_l;
        j = n - 1;
        exp_l = 1'b1;
        if (j < 5 * FRAME) exp_l = exp_txd(offer[j / FRAME], j % FRAME);
        n_total++;
        if (TXD !== exp_l)
          $display("FAIL full_txd: cycle %0d got %b expected %b", j, TXD, exp_l);
        else n_pass++;
      end
    end
    tx_valid = 1'b0;
    n_total++;
    if (busy !== 1'b0 || tx_ready !== 1'b1)
      $display("FAIL full_drain: busy=%b ready=%b expected busy=0 ready=1", busy, tx_ready);
    else n_pass++;
  endtask

  task automatic test_midframe_reset();
    logic [7:0] seq [3];
    seq[0] = 8'hA1;
    seq[1] = 8'hB2;
    seq[2] = 8'hC3;
    // Run up to the middle of data bit 3 of the first frame.
    for (int n = 0; n <= 18; n++) begin
      tx_valid = (n < 3);
      if (n < 3) tx_data = seq[n];
      tick();
      if (n >= 1) begin
        logic exp_l;
        exp_l = exp_txd(seq[0], n - 1);
        n_total++;
        if (TXD !== exp_l)
          $display("FAIL midrst_txd: cycle %0d got %b expected %b", n - 1, TXD, exp_l);
        else n_pass++;
      end
    end
    tx_valid = 1'b0;
    RESET    = 1'b1;
    #1;
    n_total++;
    if (tx_ready !== 1'b0) $display("FAIL midrst_ready_low: got %b expected 0", tx_ready);
    else n_pass++;
    tick();
    RESET = 1'b0;
    n_total++;
    if (TXD !== 1'b1 || busy !== 1'b0)
      $display("FAIL midrst_abort: txd=%b busy=%b expected txd=1 busy=0", TXD, busy);
    else n_pass++;
    #1;
    n_total++;
    if (tx_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", tx_ready);
    else n_pass++;
    for (int k = 0; k < 100; k++) begin
      tick();
      n_total++;
      if (TXD !== 1'b1 || busy !== 1'b0)
        $display("FAIL midrst_quiet: cycle %0d txd=%b busy=%b expected txd=1 busy=0", k, TXD, busy);
      else n_pass++;
    end
  endtask

  task automatic test_push_pop_same_edge();
    logic [7:0] seq [6];
    seq[0] = 8'h81; seq[1] = 8'h42; seq[2] = 8'h3C;
    seq[3] = 8'hD1; seq[4] = 8'hD2; seq[5] = 8'hD3;
    for (int n = 0; n <= 242; n++) begin
      int idx;
      idx = -1;
      if (n == 0) idx = 0;
      if (n == 1) idx = 1;
      if (n >= 41 && n <= 44) idx = n - 39;
      tx_valid = (idx >= 0);
      if (idx >= 0) tx_data = seq[idx];
      if (n >= 41 && n <= 44) begin
        n_total++;
        if (tx_ready !== 1'b1)
          $display("FAIL pp_ready: before edge %0d got %b expected 1", n, tx_ready);
        else n_pass++;
      end
      tick();
      if (n == 44) begin
        // Occupancy was 1 after the shared push/pop edge, so three more fill it.
        n_total++;
        if (tx_ready !== 1'b0)
          $display("FAIL pp_occupancy: ready after edge 44 got %b expected 0", tx_ready);
        else n_pass++;
      end
      if (n >= 1) begin
        int   j;
        logic exp_l;
        j = n - 1;
        exp_l = 1'b1;
        if (j < 6 * FRAME) exp_l = exp_txd(seq[j / FRAME], j % FRAME);
        n_total++;
        if (TXD !== exp_l)
          $display("FAIL pp_txd: cycle %0d got %b expected %b", j, TXD, exp_l);
        else n_pass++;
      end
    end
    tx_valid = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL pp_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_loopback();
    int guard;
    rx_q.delete();
    rx_ferr = 0;
    rx_en   = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      guard    = 0;
      while (tx_ready !== 1'b1 && guard < 200) begin
        tick();
        guard++;
      end
      if (guard >= 200) begin
        n_total++;
        $display("FAIL loop_ready_timeout: byte %0d ready=%b expected 1", i, tx_ready);
        break;
      end
      tick();
    end
    tx_valid = 1'b0;
    guard    = 0;
    while (busy !== 1'b0 && guard < 500) begin
      tick();
      guard++;
    end
    n_total++;
    if (guard >= 500) $display("FAIL loop_drain_timeout: busy=%b expected 0", busy);
    else n_pass++;
    repeat (8) tick();
    rx_en = 1'b0;
    n_total++;
    if (rx_q.size() != 256) $display("FAIL loop_count: got %0d expected 256", rx_q.size());
    else n_pass++;
    n_total++;
    if (rx_ferr != 0) $display("FAIL loop_framing: got %0d errors expected 0", rx_ferr);
    else n_pass++;
    for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
      n_total++;
      if (rx_q[i] !== 8'(i)) $display("FAIL loop_byte: index %0d got %h expected %h", i, rx_q[i], 8'(i));
      else n_pass++;
    end
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rx_en    = 1'b0;
    RESET    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    repeat (3) tick();
    test_single_byte();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_full_fifo();
    repeat (3) tick();
    test_midframe_reset();
    repeat (3) tick();
    test_push_pop_same_edge();
    repeat (3) tick();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 217, SHALL set the clock cycles per serial bit (217 = 25 MHz / 115200 baud); legal range 2..65535.
- REQ-002: Parameter FIFO_DEPTH, default 4, SHALL set the input FIFO capacity in bytes; legal values are powers of two from 2 to 256.
- REQ-003: Port CLK, input, 1 bit, SHALL be the single system clock; all state updates occur on its rising edge.
- REQ-004: Port RESET, input, 1 bit, SHALL be the reset; it is synchronous and active-high.
- REQ-005: Port tx_data, input, 8 bits, SHALL carry the byte offered for transmission.
- REQ-006: Port tx_valid, input, 1 bit, SHALL be high when tx_data holds a valid byte.
- REQ-007: Port tx_ready, output, 1 bit, SHALL be high when the FIFO can accept a byte.
- REQ-008: Port TXD, output, 1 bit, SHALL be the UART serial line, idle high.
- REQ-009: Port busy, output, 1 bit, SHALL be high while a frame is in progress or the FIFO is non-empty.

Function
- REQ-010: A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1, and SHALL then be written to the FIFO tail.
- REQ-011: tx_ready SHALL equal "FIFO not full"; a tx_valid asserted while tx_ready=0 SHALL be ignored, with no FIFO change.
- REQ-012: The frame format SHALL be 8N1: one start bit (0), data bits 0..7 LSB first, then one stop bit (1).
- REQ-013: The FSM SHALL have four states, IDLE, START, DATA and STOP, with a 16-bit cycle counter and a 3-bit bit index.
- REQ-014: In IDLE with the FIFO non-empty, the next edge SHALL pop the FIFO head into the shift register, enter START, drive TXD=0 and clear the counter.
- REQ-015: Every state other than IDLE SHALL last exactly CLKS_PER_BIT cycles per bit; the counter counts 0..CLKS_PER_BIT-1, and the state or bit advances on the edge where the counter equals CLKS_PER_BIT-1.
- REQ-016: START SHALL go to DATA with bit index 0; DATA SHALL drive the shift register LSB, shift right each bit period, and go to STOP after bit index 7.
- REQ-017: STOP SHALL drive TXD=1; at the end of the stop bit the FSM SHALL pop and go straight to START if the FIFO is non-empty, otherwise go to IDLE.
- REQ-018: A single isolated byte accepted at edge E SHALL produce TXD falling at edge E+1; the frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
- REQ-019: Back-to-back frames SHALL have no idle cycles between the stop bit and the next start bit.
- REQ-020: A push and a pop on the same edge SHALL leave the occupancy unchanged and preserve byte order.
- REQ-021: FIFO pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL use log2(FIFO_DEPTH)+1 bits.
- REQ-022: TXD SHALL be driven from a register, with no combinational path from any input to TXD.
- REQ-023: busy SHALL be low only when the FSM is in IDLE and the FIFO is empty.

Reset
- REQ-024: While RESET=1 at an edge, the block SHALL set: FSM=IDLE, TXD=1, FIFO empty (pointers and occupancy 0), counter 0, bit index 0, busy=0.
- REQ-025: tx_ready SHALL be 0 in any cycle where RESET=1, and 1 in the first cycle after RESET deasserts.
- REQ-026: A RESET asserted mid-frame SHALL abort the frame and discard the FIFO contents, with TXD=1 from the next edge; no partial frame resumes after reset.
- REQ-027: Data presented while RESET=1 SHALL NOT be accepted.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
- REQ-028: Single byte: push 0xA5 at edge E -> TXD=0 for E+1..E+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; busy falls at E+41.
- REQ-029: Back-to-back: push 0x00, 0xFF, 0x55 on consecutive edges -> three frames spanning exactly 120 contiguous cycles with no extra idle cycles.
- REQ-030: Full FIFO: hold tx_valid for 6 edges during the first frame -> tx_ready falls once occupancy reaches 4; a byte offered while full is not transmitted; output order matches acceptance order.
- REQ-031: Mid-frame reset: assert RESET for 1 cycle during DATA bit 3 with 2 bytes queued -> TXD=1 next edge, busy=0, tx_ready=1 afterwards, and no further frames.
- REQ-032: Simultaneous push/pop: with FIFO=1 entry at the end of STOP, push 0x3C on the pop edge -> occupancy stays 1, and 0x3C is sent next.
- REQ-033: Loopback: a behavioural UART receiver at 4 cycles per bit decodes all 256 byte values sent in sequence without error.
